// File: rtl/gpu_arb_pkg.sv
// Shared types for the GPU host-port arbiters: requester id width and read tag.
package gpu_arb_pkg;

    localparam int unsigned MAX_REQ = 4;
    localparam int unsigned ID_W    = $clog2(MAX_REQ);

    // Read-return tag carried down the latency pipe alongside each issued access
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index after last_i, wrapping.
module rr_pick
    import gpu_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]    elig_i,
    input  logic [ID_W-1:0] last_i,
    output logic [N-1:0]    win_oh_c_o,
    output logic [ID_W-1:0] win_idx_c_o,
    output logic            win_vld_c_o
);

    // Walk priority positions last+1 .. last+N; the first eligible one wins
    always_comb begin
        win_oh_c_o  = '0;
        win_idx_c_o = '0;
        win_vld_c_o = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!win_vld_c_o && elig_i[i] && (i == (32'(last_i) + k) % N)) begin
                    win_oh_c_o[i] = 1'b1;
                    win_idx_c_o   = ID_W'(i);
                    win_vld_c_o   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpu_host_port_arbiter.sv
// Round-robin arbiter sharing the gpu_RAM host port between NUM_REQ requesters,
// with tagged, fixed-latency read return.
module gpu_host_port_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = 20
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ-1:0]        wr_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic [NUM_REQ*8-1:0]      wdata_in,
    output logic [NUM_REQ-1:0]        gnt_out,
    output logic [NUM_REQ-1:0]        rd_valid_out,
    output logic [7:0]                rd_data_out,
    output logic                      ram_wr_ena,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [7:0]                ram_wr_data,
    input  logic [7:0]                ram_rd_data
);

    localparam int unsigned TAG_STAGES = READ_LATENCY + 1;

    logic [NUM_REQ-1:0] elig_c;
    logic [NUM_REQ-1:0] win_oh_c;
    logic [ID_W-1:0]    win_idx_c;
    logic               win_vld_c;
    logic [ADDR_W-1:0]  win_addr_c;
    logic [7:0]         win_wdata_c;
    logic               win_wr_c;

    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic               wr_ena_q, wr_ena_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    rd_tag_t            tag_q [TAG_STAGES];
    rd_tag_t            tag_d [TAG_STAGES];

    // Last cycle's grantee is still showing its old request, so keep it out
    assign elig_c = req_in & ~gnt_q;

    rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .elig_i      (elig_c),
        .last_i      (last_q),
        .win_oh_c_o  (win_oh_c),
        .win_idx_c_o (win_idx_c),
        .win_vld_c_o (win_vld_c)
    );

    // One-hot payload mux selecting the winner's address, data and direction
    always_comb begin
        win_addr_c  = '0;
        win_wdata_c = '0;
        win_wr_c    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh_c[i]) begin
                win_addr_c  = win_addr_c  | addr_in[i*ADDR_W +: ADDR_W];
                win_wdata_c = win_wdata_c | wdata_in[i*8 +: 8];
                win_wr_c    = win_wr_c    | wr_in[i];
            end
        end
    end

    // Next-state for the issue side, tag pipe and read-return side
    always_comb begin
        gnt_d      = win_oh_c;
        last_d     = win_vld_c ? win_idx_c   : last_q;
        addr_d     = win_vld_c ? win_addr_c  : addr_q;
        wdata_d    = win_vld_c ? win_wdata_c : wdata_q;
        wr_ena_d   = win_vld_c & win_wr_c;

        tag_d[0].valid = win_vld_c & ~win_wr_c;
        tag_d[0].id    = win_idx_c;
        for (int unsigned s = 1; s < TAG_STAGES; s++) begin
            tag_d[s] = tag_q[s-1];
        end

        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (tag_q[READ_LATENCY].valid) begin
            rd_data_d = ram_rd_data;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (tag_q[READ_LATENCY].id == ID_W'(i)) begin
                    rd_valid_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers; reset also flushes in-flight read tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            wr_ena_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            for (int unsigned s = 0; s < TAG_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            gnt_q      <= gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            last_q     <= last_d;
            wr_ena_q   <= wr_ena_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            for (int unsigned s = 0; s < TAG_STAGES; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign gnt_out      = gnt_q;
    assign rd_valid_out = rd_valid_q;
    assign rd_data_out  = rd_data_q;
    assign ram_wr_ena   = wr_ena_q;
    assign ram_addr     = addr_q;
    assign ram_wr_data  = wdata_q;

endmodule
